// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared constants and types for the register-file write path.
//   XLEN, ADDR_W, NREG : datapath width, register address width, register count
//   ZERO_REG           : x0, hard-wired to zero (writes and issues to it are ignored)
//   sel_e              : registered write-port grant (none / writeback / multi-cycle)
package rf_ctrl_pkg;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_A    = 2'd1,
      SEL_B    = 2'd2
   } sel_e;
endpackage

// File: rtl/rf_pending_scoreboard.sv
// rf_pending_scoreboard: one pending bit per register for outstanding
// multi-cycle results.
//   clk_i, rst_n_i  : clock, synchronous active-low reset
//   iss_valid_i/addr: a multi-cycle op issued, marks its destination pending
//   clr_valid_i/addr: a multi-cycle result was written, clears its destination
//   pending_o       : registered pending vector, bit 0 always 0
//   iss_conflict_o  : one-cycle pulse, an issue hit an already-pending register
import rf_ctrl_pkg::*;

module rf_pending_scoreboard (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              iss_valid_i,
   input  logic [ADDR_W-1:0] iss_addr_i,
   input  logic              clr_valid_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   output logic [NREG-1:0]   pending_o,
   output logic              iss_conflict_o
);

   logic [NREG-1:0] pending_q, pending_d;
   logic [NREG-1:0] set_vec, clr_vec;
   logic            conflict_q, conflict_d;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid_i && (iss_addr_i != ZERO_REG)) set_vec[iss_addr_i] = 1'b1;
      if (clr_valid_i) clr_vec[clr_addr_i] = 1'b1;
      // Set is applied after clear so a same-cycle issue keeps the bit.
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      pending_d[0] = 1'b0;
      conflict_d   = iss_valid_i && (iss_addr_i != ZERO_REG) && pending_q[iss_addr_i];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pending_q  <= '0;
         conflict_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         conflict_q <= conflict_d;
      end
   end

   assign pending_o      = pending_q;
   assign iss_conflict_o = conflict_q;

endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: shares the single register-file write port between the
// in-order writeback (port A) and a multi-cycle unit (port B).
//   clk_i, rst_n_i         : clock, synchronous active-low reset
//   a_valid_i/a_ready_o    : writeback handshake, a_addr_i/a_data_i payload
//   b_valid_i/b_ready_o    : multi-cycle handshake, b_addr_i/b_data_i payload
//   iss_valid_i/iss_addr_i : multi-cycle issue, marks destination pending
//   rf_we_o/rf_wa_o/rf_wd_o: registered write port, one cycle after transfer
//   pending_o              : registered scoreboard of outstanding B results
//   iss_conflict_o         : pulse when an issue hits a pending register
// A has priority unless it targets a register B still owes (WAW) or B has
// been stalled MAX_WAIT consecutive cycles, in which case B is forced through.
import rf_ctrl_pkg::*;

module rf_write_scheduler #(
   parameter int MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [XLEN-1:0]   a_data_i,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [XLEN-1:0]   b_data_i,
   input  logic              iss_valid_i,
   input  logic [ADDR_W-1:0] iss_addr_i,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_wa_o,
   output logic [XLEN-1:0]   rf_wd_o,
   output logic [NREG-1:0]   pending_o,
   output logic              iss_conflict_o
);

   localparam int              CNT_W   = 4;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   logic              a_hazard, a_xfer, b_xfer, b_stall;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              force_q, force_d;
   sel_e              grant_q, grant_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [XLEN-1:0]   wd_q, wd_d;

   // Ready terms use only registered state plus the request payload, so the
   // register file write port never sits on a long combinational path.
   assign a_hazard  = pending_o[a_addr_i] && (a_addr_i != ZERO_REG);
   assign a_ready_o = !force_q && !a_hazard;
   assign b_ready_o = force_q || !a_valid_i || a_hazard;

   // Mutually exclusive by construction: b_ready implies A is absent or blocked.
   assign a_xfer  = a_valid_i && a_ready_o;
   assign b_xfer  = b_valid_i && b_ready_o;
   assign b_stall = b_valid_i && !b_ready_o;

   rf_pending_scoreboard u_sb (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .iss_valid_i   (iss_valid_i),
      .iss_addr_i    (iss_addr_i),
      .clr_valid_i   (b_xfer),
      .clr_addr_i    (b_addr_i),
      .pending_o     (pending_o),
      .iss_conflict_o(iss_conflict_o)
   );

   // Starvation counter; force latches once B has waited MAX_WAIT cycles and
   // holds (blocking A) until B actually transfers.
   always_comb begin
      cnt_d   = cnt_q;
      force_d = force_q;
      if (b_xfer) begin
         cnt_d   = '0;
         force_d = 1'b0;
      end else if (b_stall) begin
         if (cnt_q < MAX_CNT) cnt_d = cnt_q + 1'b1;
         if (cnt_d >= MAX_CNT) force_d = 1'b1;
      end
   end

   // Writes to x0 complete the handshake but never reach the register file.
   always_comb begin
      grant_d = SEL_NONE;
      wa_d    = wa_q;
      wd_d    = wd_q;
      if (a_xfer && (a_addr_i != ZERO_REG)) begin
         grant_d = SEL_A;
         wa_d    = a_addr_i;
         wd_d    = a_data_i;
      end else if (b_xfer && (b_addr_i != ZERO_REG)) begin
         grant_d = SEL_B;
         wa_d    = b_addr_i;
         wd_d    = b_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q   <= '0;
         force_q <= 1'b0;
         grant_q <= SEL_NONE;
         wa_q    <= '0;
         wd_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         force_q <= force_d;
         grant_q <= grant_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
      end
   end

   assign rf_we_o = (grant_q != SEL_NONE);
   assign rf_wa_o = wa_q;
   assign rf_wd_o = wd_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, a_ready, b_valid, b_ready, iss_valid;
   logic [4:0]  a_addr, b_addr, iss_addr;
   logic [31:0] a_data, b_data;
   logic        rf_we, iss_conflict;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd, pending;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   rf_write_scheduler #(.MAX_WAIT(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
      .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
      .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
      .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
      .pending_o(pending), .iss_conflict_o(iss_conflict)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every register-file write must match the next expected entry.
   always @(negedge clk) begin
      if (mon_en && rf_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got wa=%0d wd=%h expected no write", rf_wa, rf_wd);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(rf_wa), 32'(e.addr));
            chk("wr_data", rf_wd, e.data);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; a_valid = 0; b_valid = 0; iss_valid = 0;
      a_addr = 0; b_addr = 0; iss_addr = 0; a_data = 0; b_data = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_we", 32'(rf_we), 0);
      chk("rst_wa", 32'(rf_wa), 0);
      chk("rst_wd", rf_wd, 0);
      chk("rst_pending", pending, 0);
      chk("rst_conflict", 32'(iss_conflict), 0);
      chk("rst_a_ready", 32'(a_ready), 1);
      chk("rst_b_ready", 32'(b_ready), 1);

      // A only
      tick();
      a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("a_only_ready", 32'(a_ready), 1);
      chk("a_only_b_ready", 32'(b_ready), 0);
      push(5, 32'hDEADBEEF);
      tick();
      a_valid = 0;

      // Starvation: A on x3 every cycle, B on x7 stalls 4 cycles then forced
      a_valid = 1; a_addr = 3; a_data = 32'h33;
      b_valid = 1; b_addr = 7; b_data = 32'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("starve_a_ready", 32'(a_ready), 1);
         chk("starve_b_ready", 32'(b_ready), 0);
         push(3, 32'h33);
         tick();
      end
      @(negedge clk);
      chk("force_a_ready", 32'(a_ready), 0);
      chk("force_b_ready", 32'(b_ready), 1);
      push(7, 32'h77);
      tick();
      b_valid = 0;
      @(negedge clk);
      chk("force_clr_a_ready", 32'(a_ready), 1);
      push(3, 32'h33);
      tick();
      a_valid = 0;

      // WAW hazard on x9
      iss_valid = 1; iss_addr = 9;
      tick();
      iss_valid = 0;
      a_valid = 1; a_addr = 9; a_data = 32'hAAAA;
      @(negedge clk);
      chk("waw_pending", pending, 32'h0000_0200);
      chk("waw_a_ready", 32'(a_ready), 0);
      chk("waw_b_ready", 32'(b_ready), 1);
      tick();
      b_valid = 1; b_addr = 9; b_data = 32'h11;
      @(negedge clk);
      chk("waw_a_blocked", 32'(a_ready), 0);
      push(9, 32'h11);
      tick();
      b_valid = 0;
      @(negedge clk);
      chk("waw_pending_clr", pending, 0);
      chk("waw_a_go", 32'(a_ready), 1);
      push(9, 32'hAAAA);
      tick();
      a_valid = 0;

      // x0 write and x0 issue
      a_valid = 1; a_addr = 0; a_data = 32'hFFFFFFFF;
      iss_valid = 1; iss_addr = 0;
      @(negedge clk);
      chk("x0_a_ready", 32'(a_ready), 1);
      tick();
      a_valid = 0; iss_valid = 0;
      @(negedge clk);
      chk("x0_we", 32'(rf_we), 0);
      chk("x0_pending", pending, 0);
      chk("x0_conflict", 32'(iss_conflict), 0);

      // Double issue on x12, then same-cycle set/clear
      tick();
      iss_valid = 1; iss_addr = 12;
      tick();
      @(negedge clk);
      chk("iss1_pending", pending, 32'h0000_1000);
      chk("iss1_conflict", 32'(iss_conflict), 0);
      tick();
      iss_valid = 0;
      @(negedge clk);
      chk("iss2_conflict", 32'(iss_conflict), 1);
      tick();
      @(negedge clk);
      chk("iss2_conflict_off", 32'(iss_conflict), 0);
      chk("iss2_pending", pending, 32'h0000_1000);
      tick();
      iss_valid = 1; iss_addr = 12;
      b_valid = 1; b_addr = 12; b_data = 32'h12;
      @(negedge clk);
      chk("setclr_b_ready", 32'(b_ready), 1);
      push(12, 32'h12);
      tick();
      iss_valid = 0; b_valid = 0;
      @(negedge clk);
      chk("setclr_pending", pending, 32'h0000_1000);
      chk("setclr_conflict", 32'(iss_conflict), 1);

      // Clear x12 (pending[12] -> 0), then build force with pending[10] set
      tick();
      b_valid = 1; b_addr = 12; b_data = 32'h55;
      push(12, 32'h55);
      tick();
      b_valid = 0;
      a_valid = 1; a_addr = 3; a_data = 32'h3;
      b_valid = 1; b_addr = 7; b_data = 32'h7;
      iss_valid = 1; iss_addr = 10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_setup_b_ready", 32'(b_ready), 0);
         push(3, 32'h3);
         tick();
         iss_valid = 0;
      end
      // Reset while forced: B would transfer but the reset drops it
      rst_n = 0; a_valid = 0;
      @(negedge clk);
      chk("pre_rst_pending", pending, 32'h0000_0400);
      chk("pre_rst_a_ready", 32'(a_ready), 0);
      tick();
      rst_n = 1; b_valid = 0;
      @(negedge clk);
      chk("mid_rst_we", 32'(rf_we), 0);
      chk("mid_rst_wa", 32'(rf_wa), 0);
      chk("mid_rst_wd", rf_wd, 0);
      chk("mid_rst_pending", pending, 0);
      chk("mid_rst_conflict", 32'(iss_conflict), 0);
      chk("mid_rst_a_ready", 32'(a_ready), 1);

      // Force and counter gone: A wins over B again
      tick();
      a_valid = 1; a_addr = 3; a_data = 32'h3333;
      b_valid = 1; b_addr = 7;
      @(negedge clk);
      chk("post_rst_a_ready", 32'(a_ready), 1);
      chk("post_rst_b_ready", 32'(b_ready), 0);
      push(3, 32'h3333);
      tick();
      a_valid = 0; b_valid = 0;
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
